ysyx_220066_wb_arb: RTL and testbench

Parametrised N-channel writeback arbiter for the ysyx_220066 core. It sits between the execution-side result producers (LSU, multiplier, divider, and future units) and the register file write port. Each channel has a valid/ready handshake and its own result FIFO. One result per cycle is committed to a registered writeback port, under fixed-priority or round-robin arbitration.

---
 rtl/ysyx_220066_wb_arb_if.sv | 41 ++++
 rtl/ysyx_220066_wb_arb.sv | 149 ++++++++++++++
 tb/tb_ysyx_220066_wb_arb.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_wb_arb_if.sv
// Writeback arbiter bus: producer handshakes, flush and retire port.
// slave is the arbiter side, master is the driver/observer side.
interface ysyx_220066_wb_arb_if #(
  parameter int NCH   = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 flush;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH-1:0]       in_wen;
  logic [NCH-1:0]       in_error;
  logic [NCH*5-1:0]     in_rd;
  logic [NCH*XLEN-1:0]  in_data;
  logic [NCH*64-1:0]    in_nxtpc;
  logic                 wb_valid;
  logic                 wen;
  logic [4:0]           rd;
  logic [XLEN-1:0]      data;
  logic [63:0]          nxtpc;
  logic                 error;
  logic [GW-1:0]        grant_ch;
  logic [NCH*CW-1:0]    occupancy;

  modport slave (
    input  flush, in_valid, in_wen, in_error,
    input  in_rd, in_data, in_nxtpc,
    output in_ready, wb_valid, wen, rd, data,
    output nxtpc, error, grant_ch, occupancy
  );

  modport master (
    output flush, in_valid, in_wen, in_error,
    output in_rd, in_data, in_nxtpc,
    input  in_ready, wb_valid, wen, rd, data,
    input  nxtpc, error, grant_ch, occupancy
  );
endinterface

// File: rtl/ysyx_220066_wb_arb.sv
// N-channel writeback arbiter: per-channel result FIFOs feeding
// one registered retire port, fixed-priority or round-robin.
module ysyx_220066_wb_arb #(
  parameter int NCH   = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int RR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_220066_wb_arb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [GW-1:0] LAST = GW'(NCH - 1);

  typedef struct packed {
    logic            wen;
    logic            error;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [63:0]     nxtpc;
  } ent_t;

  ent_t           mem [NCH][DEPTH];
  logic [AW-1:0]  wp  [NCH];
  logic [AW-1:0]  rp  [NCH];
  logic [CW-1:0]  cnt [NCH];
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  gsel;
  logic           gnt;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  ent_t           head;

  // Ready/occupancy come from registered counts only.
  always_comb begin
    bus.in_ready  = '0;
    bus.occupancy = '0;
    push          = '0;
    pop           = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.in_ready[i] = cnt[i] < FULL;
      bus.occupancy[i*CW +: CW] = cnt[i];
      push[i] = bus.in_valid[i] & (cnt[i] < FULL)
              & ~bus.flush;
      pop[i]  = gnt & (gsel == GW'(i));
    end
  end

  // Pick one non-empty channel; the last hit in each loop
  // is the first channel in search order.
  always_comb begin
    int idx;
    gnt  = 1'b0;
    gsel = '0;
    idx  = 0;
    if (!bus.flush) begin
      if (RR == 0) begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (|cnt[i]) begin
            gnt  = 1'b1;
            gsel = GW'(i);
          end
        end
      end else begin
        for (int k = NCH; k >= 1; k--) begin
          idx = (int'(ptr) + k) % NCH;
          if (|cnt[GW'(idx)]) begin
            gnt  = 1'b1;
            gsel = GW'(idx);
          end
        end
      end
    end
    head = mem[gsel][rp[gsel]];
  end

  // FIFO storage writes; push already excludes flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem[i][wp[i]] <= '{
          wen:   bus.in_wen[i],
          error: bus.in_error[i],
          rd:    bus.in_rd[i*5 +: 5],
          data:  bus.in_data[i*XLEN +: XLEN],
          nxtpc: bus.in_nxtpc[i*64 +: 64]
        };
      end
    end
  end

  // FIFO pointers, counts and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      ptr <= LAST;
    end else if (bus.flush) begin
      for (int i = 0; i < NCH; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      ptr <= LAST;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (pop[i] && !push[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
      if (RR != 0 && gnt) ptr <= gsel;
    end
  end

  // Registered retire port; payload holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid <= 1'b0;
      bus.wen      <= 1'b0;
      bus.rd       <= '0;
      bus.data     <= '0;
      bus.nxtpc    <= '0;
      bus.error    <= 1'b0;
      bus.grant_ch <= '0;
    end else begin
      bus.wb_valid <= gnt;
      if (gnt) begin
        bus.wen      <= head.wen & (|head.rd);
        bus.rd       <= head.rd;
        bus.data     <= head.data;
        bus.nxtpc    <= head.nxtpc;
        bus.error    <= head.error;
        bus.grant_ch <= gsel;
      end else begin
        bus.wen <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220066_wb_arb.sv
// Bench for ysyx_220066_wb_arb: fixed and round-robin instances
// driven identically, checked against a queue-based model.
module tb_ysyx_220066_wb_arb;
  localparam int NCH   = 3;
  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic        wen;
    logic        error;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] nxtpc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         flush;
  logic [2:0]   in_valid, in_wen, in_error;
  logic [14:0]  in_rd;
  logic [191:0] in_data, in_nxtpc;

  ysyx_220066_wb_arb_if #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) bf ();
  ysyx_220066_wb_arb_if #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) br ();

  assign bf.flush    = flush;
  assign bf.in_valid = in_valid;
  assign bf.in_wen   = in_wen;
  assign bf.in_error = in_error;
  assign bf.in_rd    = in_rd;
  assign bf.in_data  = in_data;
  assign bf.in_nxtpc = in_nxtpc;
  assign br.flush    = flush;
  assign br.in_valid = in_valid;
  assign br.in_wen   = in_wen;
  assign br.in_error = in_error;
  assign br.in_rd    = in_rd;
  assign br.in_data  = in_data;
  assign br.in_nxtpc = in_nxtpc;

  ysyx_220066_wb_arb #(
    .NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RR(0)
  ) u_fix (.clk(clk), .rst(rst), .bus(bf.slave));

  ysyx_220066_wb_arb #(
    .NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RR(1)
  ) u_rr (.clk(clk), .rst(rst), .bus(br.slave));

  int nchk = 0;
  int nfail = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  ent_t        mq [6][$];
  logic        e_v [2];
  logic        e_w [2];
  logic        e_e [2];
  logic [4:0]  e_r [2];
  logic [63:0] e_d [2];
  logic [63:0] e_p [2];
  int          e_g [2];
  int          mptr [2];

  bit collect = 0;
  int gf[$];
  int gr[$];

  task automatic model_reset();
    for (int q = 0; q < 6; q++) mq[q].delete();
    for (int m = 0; m < 2; m++) begin
      e_v[m] = 0; e_w[m] = 0; e_e[m] = 0;
      e_r[m] = 0; e_d[m] = 0; e_p[m] = 0;
      e_g[m] = 0; mptr[m] = NCH - 1;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int sz[3];
      int win;
      ent_t h;
      if (flush) begin
        for (int c = 0; c < 3; c++) mq[m*3+c].delete();
        mptr[m] = NCH - 1;
        e_v[m] = 0; e_w[m] = 0;
        continue;
      end
      for (int c = 0; c < 3; c++) sz[c] = mq[m*3+c].size();
      win = -1;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m == 0) ? k : (mptr[m] + 1 + k) % NCH;
        if (win < 0 && sz[c] > 0) win = c;
      end
      if (win >= 0) begin
        h = mq[m*3+win].pop_front();
        e_v[m] = 1;
        e_w[m] = h.wen && (h.rd != 0);
        e_e[m] = h.error;
        e_r[m] = h.rd;
        e_d[m] = h.data;
        e_p[m] = h.nxtpc;
        e_g[m] = win;
        if (m == 1) mptr[m] = win;
      end else begin
        e_v[m] = 0; e_w[m] = 0;
      end
      for (int c = 0; c < 3; c++)
        if (in_valid[c] && sz[c] < DEPTH)
          mq[m*3+c].push_back('{
            wen: in_wen[c], error: in_error[c],
            rd: in_rd[5*c +: 5],
            data: in_data[64*c +: 64],
            nxtpc: in_nxtpc[64*c +: 64]});
    end
  endtask

  task automatic cmp_out(string p, int m, logic v, logic w,
                         logic er, logic [4:0] r,
                         logic [63:0] d, logic [63:0] pc,
                         logic [1:0] g);
    check({p, "valid"}, v, e_v[m]);
    check({p, "wen"}, w, e_w[m]);
    check({p, "error"}, er, e_e[m]);
    check({p, "rd"}, r, e_r[m]);
    check({p, "data"}, d, e_d[m]);
    check({p, "nxtpc"}, pc, e_p[m]);
    check({p, "grant"}, g, e_g[m]);
  endtask

  task automatic cmp_q(string p, int m, logic [2:0] rdy,
                       logic [5:0] occ);
    for (int c = 0; c < 3; c++) begin
      int s;
      s = mq[m*3+c].size();
      check($sformatf("%sready%0d", p, c), rdy[c], s < DEPTH);
      check($sformatf("%socc%0d", p, c), occ[2*c +: 2], s);
    end
  endtask

  task automatic check_outs();
    cmp_out("fix_", 0, bf.wb_valid, bf.wen, bf.error,
            bf.rd, bf.data, bf.nxtpc, bf.grant_ch);
    cmp_out("rr_", 1, br.wb_valid, br.wen, br.error,
            br.rd, br.data, br.nxtpc, br.grant_ch);
  endtask

  task automatic check_qs();
    cmp_q("fix_", 0, bf.in_ready, bf.occupancy);
    cmp_q("rr_", 1, br.in_ready, br.occupancy);
  endtask

  task automatic cycle();
    check_qs();
    model_step();
    @(posedge clk);
    #1;
    if (collect) begin
      if (bf.wb_valid) gf.push_back(int'(bf.grant_ch));
      if (br.wb_valid) gr.push_back(int'(br.grant_ch));
    end
    check_outs();
  endtask

  task automatic clr_in();
    flush = 0; in_valid = '0; in_wen = '0; in_error = '0;
    in_rd = '0; in_data = '0; in_nxtpc = '0;
  endtask

  task automatic put(int c, logic w, logic e, logic [4:0] r,
                     logic [63:0] d, logic [63:0] pc);
    in_valid[c] = 1'b1;
    in_wen[c]   = w;
    in_error[c] = e;
    in_rd[5*c +: 5]     = r;
    in_data[64*c +: 64]  = d;
    in_nxtpc[64*c +: 64] = pc;
  endtask

  task automatic do_flush();
    clr_in();
    flush = 1;
    cycle();
    flush = 0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1;
    #1;
    model_reset();
    check_outs();
    check_qs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int exp_f[6];
    int exp_r[6];
    exp_f = '{0, 0, 1, 1, 2, 2};
    exp_r = '{0, 1, 2, 0, 1, 2};
    rst = 1;
    clr_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    check_qs();
    rst = 0;

    // single push on channel 1
    put(1, 1, 0, 5'd5, 64'hDEAD, 64'h80000004);
    cycle();
    clr_in();
    cycle();
    check("s1_valid", bf.wb_valid, 1);
    check("s1_wen", bf.wen, 1);
    check("s1_rd", bf.rd, 5);
    check("s1_data", bf.data, 64'hDEAD);
    check("s1_grant", bf.grant_ch, 1);
    cycle();
    check("s1_idle", bf.wb_valid, 0);

    // three channels at once, fixed priority
    gf.delete(); gr.delete();
    for (int c = 0; c < 3; c++)
      put(c, 1, 0, 5'(c + 1), 64'(c * 16), 64'h1000);
    cycle();
    clr_in();
    collect = 1;
    repeat (4) cycle();
    collect = 0;
    check("s2_count", gf.size(), 3);
    for (int i = 0; i < 3 && i < gf.size(); i++)
      check($sformatf("s2_g%0d", i), gf[i], i);

    // two entries per channel: both modes
    do_flush();
    gf.delete(); gr.delete();
    collect = 1;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 3; c++)
        put(c, 1, 0, 5'(8 + c), 64'(n * 4 + c), 64'h2000);
      cycle();
    end
    clr_in();
    repeat (8) cycle();
    collect = 0;
    check("s3_fcount", gf.size(), 6);
    check("s3_rcount", gr.size(), 6);
    for (int i = 0; i < 6 && i < gf.size(); i++)
      check($sformatf("s3_fg%0d", i), gf[i], exp_f[i]);
    for (int i = 0; i < 6 && i < gr.size(); i++)
      check($sformatf("s3_rg%0d", i), gr[i], exp_r[i]);

    // ch0 streams, ch2 starves and fills
    do_flush();
    for (int n = 0; n < 6; n++) begin
      put(0, 1, 0, 5'd3, 64'(n), 64'h3000);
      put(2, 1, 1, 5'd4, 64'(n + 100), 64'h3004);
      check("s4_rdy0", bf.in_ready[0], 1);
      cycle();
    end
    check("s4_rdy2", bf.in_ready[2], 0);
    check("s4_occ2", bf.occupancy[5:4], 2);
    clr_in();
    repeat (4) cycle();

    // x0 destination never writes
    put(0, 1, 0, 5'd0, 64'h1234, 64'h4000);
    cycle();
    clr_in();
    cycle();
    check("s5_valid", bf.wb_valid, 1);
    check("s5_wen", bf.wen, 0);
    cycle();

    // flush before any retire
    for (int c = 0; c < 3; c++)
      put(c, 1, 0, 5'd7, 64'h55, 64'h5000);
    cycle();
    do_flush();
    check("s6_valid0", bf.wb_valid | br.wb_valid, 0);
    cycle();
    check("s6_valid1", bf.wb_valid | br.wb_valid, 0);
    check("s6_occ", bf.occupancy | br.occupancy, 0);
    check("s6_rdy", bf.in_ready & br.in_ready, 3'b111);
    put(2, 1, 0, 5'd9, 64'h77, 64'h5004);
    cycle();
    clr_in();
    cycle();
    check("s6_after", bf.wb_valid, 1);
    check("s6_agrant", bf.grant_ch, 2);

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      clr_in();
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 2) != 0)
          put(c, 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              {32'($urandom), 32'($urandom)},
              {32'($urandom), 32'($urandom)});
      flush = ($urandom_range(0, 31) == 0);
      if (n == 200) do_reset();
      cycle();
    end
    clr_in();
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
